// File: rtl/xbus_pkg.sv
// Shared XBus arbiter definitions: FSM state encoding and default bus geometry.
package xbus_pkg;

    localparam int XBUS_WIDTH  = 11;
    localparam int XBUS_NPORTS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } xbus_state_t;

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int            pos_i;
    logic [IW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos_i = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos_i = (int'(ptr) + k) % N;
            pos   = IW'(pos_i);
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus arbiter: matches one writer to a reader (IDLE -> GRANT -> RECOVER).
// Define XBUS_BROADCAST_EN to grant every eligible reader in the same transfer.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int NPORTS = XBUS_NPORTS,
    parameter int WIDTH  = XBUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORTS-1:0]       write_req,
    input  logic [NPORTS*WIDTH-1:0] write_data,
    input  logic [NPORTS-1:0]       read_req,
    output logic [NPORTS-1:0]       write_grant,
    output logic [NPORTS-1:0]       read_grant,
    output logic [WIDTH-1:0]        read_data
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    xbus_state_t state, state_nxt;

    logic [IW-1:0]     wr_ptr, rd_ptr;
    logic [IW-1:0]     wr_sel_p1;
    logic [NPORTS-1:0] rd_mask_p1;
    logic [WIDTH-1:0]  data_p1;
`ifndef XBUS_BROADCAST_EN
    logic [IW-1:0]     rd_sel_p1;
`endif

    logic [NPORTS-1:0] eff_rd, rd_cand;
    logic [NPORTS-1:0] wr_gnt, rd_gnt;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              wr_vld, rd_vld, match;
    logic [WIDTH-1:0]  win_data;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        if (int'(p) == NPORTS - 1)
            return '0;
        return p + 1'b1;
    endfunction

    // A port requesting both directions counts only as a writer.
    assign eff_rd   = read_req & ~write_req;
    assign rd_cand  = eff_rd & ~wr_gnt;
    assign match    = wr_vld & rd_vld;
    assign win_data = write_data[int'(wr_idx)*WIDTH +: WIDTH];

    rr_pick #(.N(NPORTS), .IW(IW)) u_wr_pick (
        .req   (write_req),
        .ptr   (wr_ptr),
        .gnt   (wr_gnt),
        .idx   (wr_idx),
        .valid (wr_vld)
    );

    rr_pick #(.N(NPORTS), .IW(IW)) u_rd_pick (
        .req   (rd_cand),
        .ptr   (rd_ptr),
        .gnt   (rd_gnt),
        .idx   (rd_idx),
        .valid (rd_vld)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (match) state_nxt = GRANT;
            GRANT:   state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // IDLE -> GRANT boundary: capture winners and the word; pointers advance as GRANT ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_sel_p1  <= '0;
            rd_mask_p1 <= '0;
            data_p1    <= '0;
`ifndef XBUS_BROADCAST_EN
            rd_sel_p1  <= '0;
`endif
        end else begin
            if (state == IDLE && match) begin
                wr_sel_p1 <= wr_idx;
                data_p1   <= win_data;
`ifdef XBUS_BROADCAST_EN
                rd_mask_p1 <= rd_cand;
`else
                rd_mask_p1 <= rd_gnt;
                rd_sel_p1  <= rd_idx;
`endif
            end
            if (state == GRANT) begin
                wr_ptr <= next_ptr(wr_sel_p1);
`ifndef XBUS_BROADCAST_EN
                rd_ptr <= next_ptr(rd_sel_p1);
`endif
            end
        end
    end

    always_comb begin
        write_grant = '0;
        read_grant  = '0;
        read_data   = '0;
        if (state == GRANT) begin
            write_grant[wr_sel_p1] = 1'b1;
            read_grant             = rd_mask_p1;
            read_data              = data_p1;
        end
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: vector table, directed sequences, randomized model compare.
module tb_xbus_arbiter;

    localparam int N = 4;
    localparam int W = 11;
`ifdef XBUS_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   write_req, read_req, write_grant, read_grant;
    logic [N*W-1:0] write_data;
    logic [W-1:0]   read_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xbus_arbiter #(.NPORTS(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_req   (write_req),
        .write_data  (write_data),
        .read_req    (read_req),
        .write_grant (write_grant),
        .read_grant  (read_grant),
        .read_data   (read_data)
    );

    typedef struct {
        string          name;
        logic [N-1:0]   wr;
        logic [N-1:0]   rd;
        logic [N*W-1:0] wd;
        logic [N-1:0]   ewg;
        logic [N-1:0]   erg;
        logic [W-1:0]   ed;
    } vec_t;

    vec_t vt[8];

    // reference model state
    int           m_wp, m_rp, m_cool;
    logic [N-1:0] e_wg, e_rg;
    logic [W-1:0] e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in;
        write_req  = '0;
        read_req   = '0;
        write_data = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle_in();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [N-1:0] wg, input logic [N-1:0] rg,
                           input logic [W-1:0] d);
        chk(name, 32'({write_grant, read_grant, read_data}), 32'({wg, rg, d}));
    endtask

    // Transfer-level model: once a match is seen, the next two edges are dead time.
    task automatic model_step(input logic rst, input logic [N-1:0] wr, input logic [N-1:0] rd,
                              input logic [N*W-1:0] wd);
        int w, r, p;
        logic [N-1:0] readers;
        e_wg = '0;
        e_rg = '0;
        e_rd = '0;
        if (rst) begin
            m_wp = 0; m_rp = 0; m_cool = 0;
            return;
        end
        if (m_cool > 0) begin
            m_cool--;
            return;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            p = (m_wp + k) % N;
            if (w < 0 && wr[p]) w = p;
        end
        readers = rd & ~wr;
        if (w < 0 || readers == '0) return;
        e_wg[w] = 1'b1;
        e_rd    = wd[w*W +: W];
        m_wp    = (w + 1) % N;
        m_cool  = 2;
        if (BCAST) begin
            e_rg = readers;
        end else begin
            r = -1;
            for (int k = 0; k < N; k++) begin
                p = (m_rp + k) % N;
                if (r < 0 && readers[p]) r = p;
            end
            e_rg[r] = 1'b1;
            m_rp    = (r + 1) % N;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{"basic_p0_to_p2", 4'b0001, 4'b0100, {11'd0, 11'd0, 11'd0, 11'd42},
                  4'b0001, 4'b0100, 11'd42};
        vt[1] = '{"both_req_is_writer", 4'b0010, 4'b0110, {11'd0, 11'd0, 11'd7, 11'd0},
                  4'b0010, 4'b0100, 11'd7};
        vt[2] = '{"multi_reader", 4'b0001, 4'b1110, {11'd0, 11'd0, 11'd0, 11'd5},
                  4'b0001, BCAST ? 4'b1110 : 4'b0010, 11'd5};
        vt[3] = '{"lone_writer", 4'b0001, 4'b0000, {11'd0, 11'd0, 11'd0, 11'd9},
                  4'b0000, 4'b0000, 11'd0};
        vt[4] = '{"lone_readers", 4'b0000, 4'b1111, {N*W{1'b0}}, 4'b0000, 4'b0000, 11'd0};
        vt[5] = '{"all_writers", 4'b1111, 4'b1111, {11'd4, 11'd3, 11'd2, 11'd1},
                  4'b0000, 4'b0000, 11'd0};
        vt[6] = '{"max_word_p3_to_p0", 4'b1000, 4'b0001, {11'd2047, 11'd0, 11'd0, 11'd0},
                  4'b1000, 4'b0001, 11'd2047};
        vt[7] = '{"rr_from_zero", 4'b0110, 4'b1001, {11'd0, 11'd200, 11'd100, 11'd0},
                  4'b0010, 4'b0001, 11'd100};

        reset = 1'b1;
        idle_in();
        tick();

        // reset holds everything low even with requests present
        write_req = 4'b0001;
        read_req  = 4'b0010;
        write_data[0 +: W] = 11'd77;
        tick();
        chk_out("reset_hold", '0, '0, '0);
        reset = 1'b0;
        idle_in();
        tick();
        chk_out("after_reset", '0, '0, '0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            write_req  = vt[i].wr;
            read_req   = vt[i].rd;
            write_data = vt[i].wd;
            tick();
            chk(vt[i].name, 32'(write_grant), 32'(vt[i].ewg));
            chk(vt[i].name, 32'(read_grant), 32'(vt[i].erg));
            chk(vt[i].name, 32'(read_data), 32'(vt[i].ed));
            idle_in();
            tick();
            chk_out({vt[i].name, "_recover"}, '0, '0, '0);
        end

        // held requests: one transfer every 3 cycles, writers alternate 10,20,10
        do_reset();
        write_req = 4'b0011;
        write_data[0 +: W] = 11'd10;
        write_data[W +: W] = 11'd20;
        read_req = 4'b1000;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c % 3 == 0)
                chk_out("rr_writers", ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0010, 4'b1000,
                        ((c / 3) % 2 == 0) ? 11'd10 : 11'd20);
            else
                chk_out("rr_writers_gap", '0, '0, '0);
        end

        // lone writer waits, then completes when a reader shows up
        do_reset();
        write_req = 4'b0001;
        write_data[0 +: W] = 11'd1234;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk_out("lone_writer_wait", '0, '0, '0);
        end
        read_req = 4'b1000;
        tick();
        chk_out("late_reader", 4'b0001, 4'b1000, 11'd1234);

        // reset during GRANT clears grants and pointers
        do_reset();
        write_req = 4'b0010;
        read_req  = 4'b0100;
        write_data[W +: W] = 11'd33;
        tick();
        chk_out("pre_xfer", 4'b0010, 4'b0100, 11'd33);
        idle_in();
        tick();
        tick();
        write_req = 4'b0001;
        read_req  = 4'b0010;
        write_data[0 +: W] = 11'd44;
        tick();
        chk(BCAST ? "mid_grant_bc" : "mid_grant", 32'(write_grant), 32'(4'b0001));
        reset = 1'b1;
        idle_in();
        tick();
        chk_out("reset_in_grant", '0, '0, '0);
        reset = 1'b0;
        write_req = 4'b0110;
        read_req  = 4'b1001;
        write_data[W +: W]   = 11'd55;
        write_data[2*W +: W] = 11'd66;
        tick();
        chk_out("ptrs_cleared", 4'b0010, BCAST ? 4'b1001 : 4'b0001, 11'd55);

        // randomized traffic against the model, with occasional resets
        do_reset();
        model_step(1'b1, '0, '0, '0);
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            write_req = N'($urandom) & N'($urandom);
            read_req  = N'($urandom);
            for (int p = 0; p < N; p++) write_data[p*W +: W] = W'($urandom);
            model_step(reset, write_req, read_req, write_data);
            tick();
            chk("rand_write_grant", 32'(write_grant), 32'(e_wg));
            chk("rand_read_grant", 32'(read_grant), 32'(e_rg));
            chk("rand_read_data", 32'(read_data), 32'(e_rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
